// File: rtl/nav_cmd_sequencer_pkg.sv
// nav_pkg: heading codes, FSM state type and heading helpers
// shared by the navigation command sequencer and its position tracker.
package nav_pkg;

    localparam logic [2:0] HDG_N = 3'b001;
    localparam logic [2:0] HDG_O = 3'b010;
    localparam logic [2:0] HDG_L = 3'b011;
    localparam logic [2:0] HDG_S = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_TURN_WAIT,
        ST_MOVE,
        ST_MOVE_WAIT,
        ST_DONE
    } state_t;

    function automatic logic dir_valid(input logic [2:0] d);
        return (d == HDG_N) || (d == HDG_O) ||
               (d == HDG_L) || (d == HDG_S);
    endfunction

    // Rotation order is N -> O -> S -> L -> N
    function automatic logic [2:0] next_heading(input logic [2:0] h);
        logic [2:0] n;
        n = HDG_N;
        unique case (h)
            HDG_N:   n = HDG_O;
            HDG_O:   n = HDG_S;
            HDG_S:   n = HDG_L;
            default: n = HDG_N;
        endcase
        return n;
    endfunction

    // Position of a heading in the rotation ring
    function automatic logic [1:0] hdg_idx(input logic [2:0] h);
        logic [1:0] i;
        i = 2'd0;
        unique case (h)
            HDG_O:   i = 2'd1;
            HDG_S:   i = 2'd2;
            HDG_L:   i = 2'd3;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

    // Forward-only turn count, modulo 4 by the 2-bit width
    function automatic logic [1:0] rot_distance(input logic [2:0] h,
                                                input logic [2:0] t);
        return hdg_idx(t) - hdg_idx(h);
    endfunction

endpackage

// File: rtl/nav_cmd_sequencer_if.sv
// Move-request handshake between planner (master) and sequencer (slave).
// Ports: cmd_valid, cmd_dir[2:0] from master; cmd_ready from slave.
interface nav_cmd_sequencer_if;
    logic       cmd_valid;
    logic [2:0] cmd_dir;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/nav_pos_tracker.sv
// nav_pos_tracker: registered (x,y) grid position, one step per strobe
// in the current heading. Ports: clk, reset, i_heading, i_step,
// o_pos_x, o_pos_y, o_edge_hit (combinational: a step would leave the grid).
module nav_pos_tracker
    import nav_pkg::*;
#(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int X0     = 0,
    parameter int Y0     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2:0]                i_heading,
    input  logic                      i_step,
    output logic [$clog2(GRID_W)-1:0] o_pos_x,
    output logic [$clog2(GRID_H)-1:0] o_pos_y,
    output logic                      o_edge_hit
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    always_comb begin
        o_edge_hit = 1'b0;
        unique case (i_heading)
            HDG_N:   o_edge_hit = (r_y == YMAX);
            HDG_S:   o_edge_hit = (r_y == '0);
            HDG_L:   o_edge_hit = (r_x == XMAX);
            HDG_O:   o_edge_hit = (r_x == '0);
            default: o_edge_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= XW'(X0);
            r_y <= YW'(Y0);
        end else if (i_step) begin
            unique case (i_heading)
                HDG_N:   r_y <= r_y + 1'b1;
                HDG_S:   r_y <= r_y - 1'b1;
                HDG_L:   r_x <= r_x + 1'b1;
                HDG_O:   r_x <= r_x - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_pos_x = r_x;
    assign o_pos_y = r_y;
endmodule

// File: rtl/nav_cmd_sequencer.sv
// nav_cmd_sequencer: turns absolute move requests into girar/avancar pulses.
// Ports: clk, reset, cmd (slave handshake), girar, avancar, heading, pos_x/y,
// busy, done, blocked, err_invalid.
module nav_cmd_sequencer
    import nav_pkg::*;
#(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int SETTLE = 2,
    parameter int X0     = 0,
    parameter int Y0     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    nav_cmd_sequencer_if.slave        cmd,
    output logic                      girar,
    output logic                      avancar,
    output logic [2:0]                heading,
    output logic [$clog2(GRID_W)-1:0] pos_x,
    output logic [$clog2(GRID_H)-1:0] pos_y,
    output logic                      busy,
    output logic                      done,
    output logic                      blocked,
    output logic                      err_invalid
);
    state_t     r_state;
    state_t     w_nxt;
    logic [2:0] r_hdg;
    logic [2:0] r_tgt;
    logic [3:0] r_cnt;
    logic       r_blk;
    logic       r_err;
    logic       w_idle;
    logic       w_acc;
    logic       w_step;
    logic       w_edge;
    logic       w_expire;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_acc    = w_idle && cmd.cmd_valid && dir_valid(cmd.cmd_dir);
    // Counter is loaded with SETTLE, so the wait lasts SETTLE cycles
    assign w_expire = (r_cnt == 4'd1);

    always_comb begin
        w_nxt  = r_state;
        w_step = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc)
                    w_nxt = (rot_distance(r_hdg, cmd.cmd_dir) != 2'd0)
                          ? ST_TURN : ST_MOVE;
            end
            ST_TURN: w_nxt = ST_TURN_WAIT;
            ST_TURN_WAIT: begin
                if (w_expire)
                    w_nxt = (r_hdg == r_tgt) ? ST_MOVE : ST_TURN;
            end
            ST_MOVE: begin
                if (w_edge) begin
                    w_nxt = ST_DONE;
                end else begin
                    w_step = 1'b1;
                    w_nxt  = ST_MOVE_WAIT;
                end
            end
            ST_MOVE_WAIT: if (w_expire) w_nxt = ST_DONE;
            ST_DONE:      w_nxt = ST_IDLE;
            default:      w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_hdg   <= HDG_N;
            r_tgt   <= HDG_N;
            r_cnt   <= 4'd0;
            r_blk   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_err   <= w_idle && cmd.cmd_valid && !dir_valid(cmd.cmd_dir);
            if (w_acc) begin
                r_tgt <= cmd.cmd_dir;
                r_blk <= 1'b0;
            end
            unique case (r_state)
                ST_TURN: begin
                    r_hdg <= next_heading(r_hdg);
                    r_cnt <= 4'(SETTLE);
                end
                ST_TURN_WAIT, ST_MOVE_WAIT: r_cnt <= r_cnt - 4'd1;
                ST_MOVE: begin
                    if (w_edge) r_blk <= 1'b1;
                    else        r_cnt <= 4'(SETTLE);
                end
                default: ;
            endcase
        end
    end

    // Heading equals target in MOVE, so the shadow heading drives the step
    nav_pos_tracker #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X0     (X0),
        .Y0     (Y0)
    ) u_pos (
        .clk        (clk),
        .reset      (reset),
        .i_heading  (r_hdg),
        .i_step     (w_step),
        .o_pos_x    (pos_x),
        .o_pos_y    (pos_y),
        .o_edge_hit (w_edge)
    );

    assign cmd.cmd_ready = w_idle;
    assign busy          = !w_idle;
    assign girar         = (r_state == ST_TURN);
    assign avancar       = w_step;
    assign done          = (r_state == ST_DONE);
    assign blocked       = (r_state == ST_DONE) && r_blk;
    assign err_invalid   = r_err;
    assign heading       = r_hdg;
endmodule
